// File: rtl/lsu.sv
// Load/store unit: captures one memory operation, runs it over a valid/ready word bus,
// and returns the lane-aligned, sign/zero-extended load result on mem_r.
module lsu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic            is_load,
  input  logic            is_store,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] mem_r,
  output logic            lsu_done,
  output logic            lsu_err,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_wen,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_wstrb,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state_r;
  logic [2:0]      funct3_r;
  logic [1:0]      off_r;
  logic            is_load_r;

  logic            accept_s;
  logic            legal_s;
  logic            rsp_take_s;
  logic [XLEN-1:0] load_val_s;

  // Size/alignment legality; BU/HU exist only for loads.
  function automatic logic legal_f(input logic ld, input logic st,
                                   input logic [2:0] f3, input logic [1:0] o);
    logic ok;
    ok = 1'b0;
    if (ld && st) begin
      ok = 1'b0;
    end else begin
      case (f3)
        3'b000:  ok = 1'b1;
        3'b001:  ok = ~o[0];
        3'b010:  ok = (o == 2'b00);
        3'b100:  ok = ld;
        3'b101:  ok = ld & ~o[0];
        default: ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  function automatic logic [3:0] strb_f(input logic [2:0] f3, input logic [1:0] o);
    logic [3:0] s;
    s = 4'b0000;
    case (f3[1:0])
      2'b00:   s = 4'b0001 << o;
      2'b01:   s = 4'b0011 << o;
      2'b10:   s = 4'b1111;
      default: s = 4'b0000;
    endcase
    return s;
  endfunction

  function automatic logic [XLEN-1:0] wdata_f(input logic [2:0] f3, input logic [XLEN-1:0] d);
    logic [XLEN-1:0] w;
    w = d;
    case (f3[1:0])
      2'b00:   w = {(XLEN/8){d[7:0]}};
      2'b01:   w = {(XLEN/16){d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  function automatic logic [XLEN-1:0] load_f(input logic [2:0] f3, input logic [1:0] o,
                                             input logic [XLEN-1:0] rd);
    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] v;
    sh = rd >> {o, 3'b000};
    case (f3)
      3'b000:  v = {{(XLEN-8){sh[7]}}, sh[7:0]};
      3'b001:  v = {{(XLEN-16){sh[15]}}, sh[15:0]};
      3'b100:  v = {{(XLEN-8){1'b0}}, sh[7:0]};
      3'b101:  v = {{(XLEN-16){1'b0}}, sh[15:0]};
      default: v = sh;
    endcase
    return v;
  endfunction

  // Request acceptance, legality and response-consume decode.
  always_comb begin
    accept_s   = lsu_valid & lsu_ready & (is_load | is_store);
    legal_s    = legal_f(is_load, is_store, funct3, addr[1:0]);
    rsp_take_s = mem_rsp_valid & (((state_r == REQ) & mem_req_ready) | (state_r == WAIT));
    load_val_s = load_f(funct3_r, off_r, mem_rdata);
  end

  // Control FSM with all bus and result outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      funct3_r      <= 3'b000;
      off_r         <= 2'b00;
      is_load_r     <= 1'b0;
      lsu_ready     <= 1'b1;
      lsu_done      <= 1'b0;
      lsu_err       <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_addr      <= {XLEN{1'b0}};
      mem_wen       <= 1'b0;
      mem_wdata     <= {XLEN{1'b0}};
      mem_wstrb     <= 4'b0000;
      mem_r         <= {XLEN{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          lsu_done <= 1'b0;
          lsu_err  <= 1'b0;
          if (accept_s) begin
            funct3_r  <= funct3;
            off_r     <= addr[1:0];
            is_load_r <= is_load;
            lsu_ready <= 1'b0;
            if (legal_s) begin
              state_r       <= REQ;
              mem_req_valid <= 1'b1;
              mem_addr      <= {addr[XLEN-1:2], 2'b00};
              mem_wen       <= is_store;
              mem_wdata     <= wdata_f(funct3, wdata);
              mem_wstrb     <= is_store ? strb_f(funct3, addr[1:0]) : 4'b0000;
            end else begin
              state_r  <= DONE;
              lsu_done <= 1'b1;
              lsu_err  <= 1'b1;
            end
          end
        end
        REQ, WAIT: begin
          if (state_r == REQ && mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state_r       <= WAIT;
          end
          if (rsp_take_s) begin
            state_r  <= DONE;
            lsu_done <= 1'b1;
            lsu_err  <= 1'b0;
            if (is_load_r) begin
              mem_r <= load_val_s;
            end
          end
        end
        DONE: begin
          state_r   <= IDLE;
          lsu_done  <= 1'b0;
          lsu_err   <= 1'b0;
          lsu_ready <= 1'b1;
        end
        default: begin
          state_r       <= IDLE;
          lsu_ready     <= 1'b1;
          lsu_done      <= 1'b0;
          lsu_err       <= 1'b0;
          mem_req_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: expected completions are queued at request time and
// compared when lsu_done pulses; a scripted bus model answers each request.
module tb_lsu;
  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_valid, lsu_ready, is_load, is_store;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, mem_r, mem_addr, mem_wdata, mem_rdata;
  logic        lsu_done, lsu_err, mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid;
  logic [3:0]  mem_wstrb;

  typedef struct {
    int          id;
    logic [31:0] mr;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   op_id    = 0;

  lsu #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .lsu_valid(lsu_valid), .lsu_ready(lsu_ready),
    .is_load(is_load), .is_store(is_store), .funct3(funct3), .addr(addr),
    .wdata(wdata), .mem_r(mem_r), .lsu_done(lsu_done), .lsu_err(lsu_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Completion monitor: every lsu_done must match the oldest queued expectation.
  always @(negedge clk) begin
    if (lsu_done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk($sformatf("op%0d_mem_r", e.id), mem_r, e.mr);
        chk($sformatf("op%0d_err", e.id), {31'd0, lsu_err}, {31'd0, e.err});
        chk($sformatf("op%0d_done_cyc", e.id), 32'(cyc), 32'(e.cyc));
        chk($sformatf("op%0d_ready_in_done", e.id), {31'd0, lsu_ready}, 32'd0);
      end
    end
  end

  task automatic run_op(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rword,
                        input int rdly, input int sdly, input bit legal,
                        input logic [3:0] e_strb, input logic [31:0] e_wdata,
                        input logic [31:0] e_mr);
    exp_t  e;
    int    t0;
    int    n;
    bit    ok;
    string tg;
    op_id++;
    tg = $sformatf("op%0d", op_id);
    @(negedge clk);
    n = 0;
    while (lsu_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    t0 = cyc;
    lsu_valid = 1'b1; is_load = ld; is_store = st; funct3 = f3; addr = a; wdata = wd;
    e.id = op_id; e.mr = e_mr; e.err = !legal;
    e.cyc = legal ? (t0 + 2 + rdly + sdly) : (t0 + 1);
    sb.push_back(e);
    @(negedge clk);
    lsu_valid = 1'b0; is_load = 1'b0; is_store = 1'b0; addr = 32'hFFFF_FFFF; wdata = 32'h5555_5555;
    if (legal) begin
      chk({tg, "_req_valid"}, {31'd0, mem_req_valid}, 32'd1);
      chk({tg, "_addr"}, mem_addr, {a[31:2], 2'b00});
      chk({tg, "_wen"}, {31'd0, mem_wen}, {31'd0, st});
      chk({tg, "_wstrb"}, {28'd0, mem_wstrb}, {28'd0, e_strb});
      if (st) chk({tg, "_wdata"}, mem_wdata, e_wdata);
      ok = 1'b1;
      for (int i = 0; i < rdly; i++) begin
        @(negedge clk);
        if (mem_req_valid !== 1'b1 || lsu_ready !== 1'b0 || mem_addr !== {a[31:2], 2'b00} ||
            mem_wstrb !== e_strb || mem_wen !== st) ok = 1'b0;
      end
      if (rdly > 0) chk({tg, "_req_stable"}, {31'd0, ok}, 32'd1);
      mem_req_ready = 1'b1;
      if (sdly == 0) begin
        mem_rsp_valid = 1'b1;
        mem_rdata     = rword;
      end
      @(negedge clk);
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
      if (sdly > 0) begin
        chk({tg, "_wait_no_req"}, {31'd0, mem_req_valid}, 32'd0);
        repeat (sdly - 1) @(negedge clk);
        mem_rsp_valid = 1'b1; mem_rdata = rword;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
      end
      mem_rdata = 32'h0BAD_0BAD;
    end
    ok = (mem_req_valid === 1'b0) || legal;
    n = 0;
    while (lsu_done !== 1'b1 && n < 100) begin
      @(negedge clk);
      if (!legal && mem_req_valid !== 1'b0) ok = 1'b0;
      n++;
    end
    if (n >= 100) chk({tg, "_timeout"}, 32'd0, 32'd1);
    @(negedge clk);
    if (!legal && mem_req_valid !== 1'b0) ok = 1'b0;
    if (!legal) chk({tg, "_no_bus"}, {31'd0, ok}, 32'd1);
    chk({tg, "_ready_after"}, {31'd0, lsu_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    rst = 1'b1; lsu_valid = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = 3'b000;
    addr = 32'd0; wdata = 32'd0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, lsu_ready}, 32'd1);
    chk("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
    chk("rst_done", {31'd0, lsu_done}, 32'd0);
    chk("rst_mem_r", mem_r, 32'd0);
    chk("rst_wstrb", {28'd0, mem_wstrb}, 32'd0);
    rst = 1'b0;

    //     ld    st    f3      addr          wdata         rdata        rd sd legal strb     wdata          mem_r
    run_op(1'b1, 1'b0, 3'b000, 32'h8000_0003, 32'h0,        32'h80FF_1234, 0, 0, 1, 4'b0000, 32'h0,        32'hFFFF_FF80);
    run_op(1'b1, 1'b0, 3'b101, 32'h8000_0002, 32'h0,        32'hBEEF_0000, 0, 0, 1, 4'b0000, 32'h0,        32'h0000_BEEF);
    run_op(1'b1, 1'b0, 3'b001, 32'h8000_0002, 32'h0,        32'hBEEF_0000, 0, 0, 1, 4'b0000, 32'h0,        32'hFFFF_BEEF);
    run_op(1'b0, 1'b1, 3'b000, 32'h8000_0001, 32'h1234_56AB, 32'h0,        0, 0, 1, 4'b0010, 32'hABAB_ABAB, 32'hFFFF_BEEF);
    run_op(1'b1, 1'b0, 3'b010, 32'h8000_0002, 32'h0,        32'h0,        0, 0, 0, 4'b0000, 32'h0,        32'hFFFF_BEEF);
    run_op(1'b1, 1'b0, 3'b011, 32'h8000_0000, 32'h0,        32'h0,        0, 0, 0, 4'b0000, 32'h0,        32'hFFFF_BEEF);
    run_op(1'b1, 1'b0, 3'b010, 32'h8000_0004, 32'h0,        32'hCAFE_F00D, 3, 2, 1, 4'b0000, 32'h0,       32'hCAFE_F00D);
    run_op(1'b0, 1'b1, 3'b001, 32'h8000_0002, 32'h0000_BEEF, 32'h0,        1, 1, 1, 4'b1100, 32'hBEEF_BEEF, 32'hCAFE_F00D);
    run_op(1'b0, 1'b1, 3'b010, 32'h8000_0000, 32'hDEAD_BEEF, 32'h0,        0, 0, 1, 4'b1111, 32'hDEAD_BEEF, 32'hCAFE_F00D);
    run_op(1'b1, 1'b0, 3'b100, 32'h8000_0001, 32'h0,        32'h0000_8100, 0, 0, 1, 4'b0000, 32'h0,        32'h0000_0081);
    run_op(1'b0, 1'b1, 3'b100, 32'h8000_0000, 32'h0,        32'h0,        0, 0, 0, 4'b0000, 32'h0,        32'h0000_0081);
    run_op(1'b1, 1'b1, 3'b000, 32'h8000_0000, 32'h0,        32'h0,        0, 0, 0, 4'b0000, 32'h0,        32'h0000_0081);

    // lsu_valid with neither load nor store is ignored
    @(negedge clk);
    lsu_valid = 1'b1; is_load = 1'b0; is_store = 1'b0;
    ok = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (lsu_ready !== 1'b1 || lsu_done !== 1'b0 || mem_req_valid !== 1'b0) ok = 1'b0;
    end
    lsu_valid = 1'b0;
    chk("nop_ignored", {31'd0, ok}, 32'd1);

    // Reset while waiting for a response; the late response must be dropped
    @(negedge clk);
    lsu_valid = 1'b1; is_load = 1'b1; funct3 = 3'b010; addr = 32'h8000_0008;
    @(negedge clk);
    lsu_valid = 1'b0; is_load = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    chk("wait_req_low", {31'd0, mem_req_valid}, 32'd0);
    chk("wait_ready_low", {31'd0, lsu_ready}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_ready", {31'd0, lsu_ready}, 32'd1);
    chk("mid_rst_req", {31'd0, mem_req_valid}, 32'd0);
    chk("mid_rst_addr", mem_addr, 32'd0);
    chk("mid_rst_wdata", mem_wdata, 32'd0);
    chk("mid_rst_wen_strb", {27'd0, mem_wen, mem_wstrb}, 32'd0);
    chk("mid_rst_done_err", {30'd0, lsu_done, lsu_err}, 32'd0);
    chk("mid_rst_mem_r", mem_r, 32'd0);
    mem_rsp_valid = 1'b1; mem_rdata = 32'h7777_7777;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    ok = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (lsu_done !== 1'b0) ok = 1'b0;
    end
    chk("late_rsp_no_done", {31'd0, ok}, 32'd1);
    chk("late_rsp_mem_r", mem_r, 32'd0);

    run_op(1'b1, 1'b0, 3'b010, 32'h8000_0000, 32'h0, 32'h1122_3344, 0, 0, 1, 4'b0000, 32'h0, 32'h1122_3344);

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit sitting directly upstream of the writeback mux; it produces the `mem_r` value that writeback selects when `rd_is_mem` is set.
- Accepts one memory operation per request from the execute stage and drives a word-wide valid/ready memory bus through a small FSM.
- Aligns and strobes store data, and extracts plus sign/zero-extends load data.
- Detects misaligned or illegal accesses without touching the bus.

Parameters:
- XLEN, 32, data/address width; equals `ISA_WIDTH`.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- lsu_valid  input  1  execute stage presents a memory operation
- lsu_ready  output  1  LSU idle; request accepted when `lsu_valid & lsu_ready`
- is_load  input  1  operation is a load
- is_store  input  1  operation is a store (`is_load & is_store` is illegal and flags `lsu_err`)
- funct3  input  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only)
- addr  input  XLEN  byte address (ALU result)
- wdata  input  XLEN  store source (rs2)
- mem_r  output  XLEN  extended load result; holds its value until the next load completes
- lsu_done  output  1  one-cycle pulse when the operation finishes
- lsu_err  output  1  valid with `lsu_done`; misaligned or illegal access
- mem_req_valid  output  1  bus request
- mem_req_ready  input  1  bus accepts request
- mem_addr  output  XLEN  word-aligned address `{addr[XLEN-1:2], 2'b00}`
- mem_wen  output  1  1 = write
- mem_wdata  output  XLEN  store data shifted into its byte lane(s)
- mem_wstrb  output  4  byte enables for writes; 0 for reads
- mem_rsp_valid  input  1  read data or write acknowledge
- mem_rdata  input  XLEN  full aligned read word

Behaviour:
- Reset values: state IDLE; `lsu_ready`=1; `mem_req_valid`, `mem_wen`, `lsu_done`, `lsu_err`=0; `mem_addr`, `mem_wdata`, `mem_wstrb`, `mem_r`=0.
- Request capture: on acceptance, register `addr`, `funct3`, the load/store flag and `wdata`. Inputs are ignored afterwards.
- States:
  - IDLE: `lsu_ready`=1.
    - Accepted legal request goes to REQ.
    - Accepted illegal request goes to DONE with the error flagged.
    - `lsu_valid` with neither load nor store set is ignored and stays in IDLE.
  - REQ: `mem_req_valid`=1; address, `mem_wen`, `mem_wdata` and `mem_wstrb` stay stable until the handshake.
    - `mem_req_ready`=1 goes to WAIT.
    - If `mem_rsp_valid` is also 1 in the handshake cycle, the response is consumed immediately and the state goes to DONE.
  - WAIT: `mem_req_valid`=0. `mem_rsp_valid`=1 goes to DONE. Any response outside REQ/WAIT is ignored.
  - DONE: `lsu_done`=1 for exactly one cycle, `lsu_err` as latched, then IDLE. `lsu_ready`=0 in every state except IDLE.
- Latency:
  - A zero-wait bus (ready and response in the same cycle) gives acceptance at T, request at T+1, `lsu_done` at T+2, and the next acceptance at T+3.
  - An illegal request gives `lsu_done` at T+1.
- Legality:
  - H/HU requires `addr[0]`=0; W requires `addr[1:0]`=00.
  - Other `funct3` codes are illegal, and so are BU/HU on a store. All of these give `lsu_err`=1.
  - On error, `mem_r` is unchanged and no bus request is issued.
- Store lanes (o = `addr[1:0]`):
  - B: wstrb = 0001<<o; wdata = `{4{wdata[7:0]}}`.
  - H: wstrb = 0011<<o; wdata = `{2{wdata[15:0]}}`.
  - W: wstrb = 1111; wdata unchanged.
- Load extract: `mem_rdata >> (8*o)`, then take the low 8 or 16 bits. B/H sign-extend, BU/HU zero-extend, W passes through. `mem_r` updates on the cycle entering DONE and is valid while `lsu_done`=1.
- Stores leave `mem_r` unchanged.
- Reset asserted in any state returns to IDLE at the next edge and drops `mem_req_valid` immediately. An in-flight response is discarded.

Test Plan:
- Load LB at addr 0x8000_0003 with rdata 0x80FF_1234 -> wstrb 0, mem_addr 0x8000_0000, mem_r 0xFFFF_FF80, done at T+2.
- LHU at 0x8000_0002 with rdata 0xBEEF_0000 -> mem_r 0x0000_BEEF. LH at the same address -> 0xFFFF_BEEF.
- SB wdata 0x1234_56AB at 0x8000_0001 -> wstrb 0010, mem_wdata 0xABAB_ABAB, mem_wen 1, mem_r unchanged.
- LW at 0x8000_0002 -> lsu_done and lsu_err at T+1, no mem_req_valid ever, mem_r unchanged. Repeat with `funct3`=011.
- `mem_req_ready` held low 3 cycles, then the response 2 cycles after the handshake -> request fields stable throughout, exactly one `lsu_done` pulse, `lsu_ready` low until after DONE.
- `rst` pulsed while in WAIT -> IDLE with all outputs at reset values next cycle. A late `mem_rsp_valid` produces no `lsu_done`.
